// File: rtl/program_loader.sv
// Boot loader sitting between the UART receive FIFO and instruction memory.
// Consumes a length-prefixed byte stream, packs bytes into instruction words,
// writes them to sequential addresses, optionally checks a trailing checksum
// byte and then releases the CPU by raising in_execution.
module program_loader #(
    parameter int WORD_BYTES  = 4,
    parameter int ADDR_WIDTH  = 16,
    parameter int LEN_BYTES   = 2,
    parameter int BIG_ENDIAN  = 1,
    parameter int CHECKSUM_EN = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [7:0]                rx_data,
    input  logic                      rx_valid,
    output logic                      rx_pop,
    input  logic                      restart,
    output logic                      write_enable,
    output logic [ADDR_WIDTH-1:0]     write_address,
    output logic [8*WORD_BYTES-1:0]   write_data,
    output logic                      in_execution,
    output logic                      load_error,
    output logic [ADDR_WIDTH-1:0]     loaded_words
);

    localparam int WORD_W = 8 * WORD_BYTES;
    localparam int LEN_W  = 8 * LEN_BYTES;

    typedef enum logic [1:0] {
        HEADER  = 2'd0,
        PAYLOAD = 2'd1,
        CHECK   = 2'd2,
        EXEC    = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [LEN_W-1:0]      len_q, len_d;
    logic [LEN_W-1:0]      word_cnt_q, word_cnt_d;
    logic [7:0]            byte_cnt_q, byte_cnt_d;
    logic [WORD_W-1:0]     word_q, word_d;
    logic [7:0]            csum_q, csum_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [WORD_W-1:0]     wdata_q, wdata_d;
    logic                  in_exec_q, in_exec_d;
    logic                  load_err_q, load_err_d;
    logic [ADDR_WIDTH-1:0] loaded_words_q, loaded_words_d;

    logic                  accept;
    logic [LEN_W-1:0]      len_shift;
    logic [WORD_W-1:0]     word_next;
    logic [7:0]            byte_pos;
    logic                  last_word;

    // A byte is taken whenever one is offered, we are not being restarted or
    // reset, and the CPU does not own the FIFO yet.
    assign accept = rx_valid & ~restart & ~reset & (state_q != EXEC);
    assign rx_pop = accept;

    assign write_enable  = we_q;
    assign write_address = waddr_q;
    assign write_data    = wdata_q;
    assign in_execution  = in_exec_q;
    assign load_error    = load_err_q;
    assign loaded_words  = loaded_words_q;

    // Helper values: header shift, byte slot for the incoming payload byte,
    // and the partially assembled word with that byte merged in.
    always_comb begin
        len_shift = (len_q << 8) | LEN_W'(rx_data);
        if (BIG_ENDIAN != 0) begin
            byte_pos = 8'(WORD_BYTES - 1) - byte_cnt_q;
        end else begin
            byte_pos = byte_cnt_q;
        end
        word_next = word_q;
        for (int i = 0; i < WORD_BYTES; i++) begin
            if (byte_pos == 8'(i)) begin
                word_next[i*8 +: 8] = rx_data;
            end
        end
        last_word = ((word_cnt_q + LEN_W'(1)) == len_q);
    end

    // Next-state logic for the loader FSM and all of its datapath registers;
    // restart overrides everything, otherwise state moves only on an accepted byte.
    always_comb begin
        state_d        = state_q;
        len_d          = len_q;
        word_cnt_d     = word_cnt_q;
        byte_cnt_d     = byte_cnt_q;
        word_d         = word_q;
        csum_d         = csum_q;
        addr_d         = addr_q;
        we_d           = 1'b0;
        waddr_d        = waddr_q;
        wdata_d        = wdata_q;
        in_exec_d      = in_exec_q;
        load_err_d     = load_err_q;
        loaded_words_d = loaded_words_q;

        if (restart) begin
            state_d    = HEADER;
            in_exec_d  = 1'b0;
            len_d      = '0;
            word_cnt_d = '0;
            byte_cnt_d = '0;
            word_d     = '0;
            csum_d     = '0;
            addr_d     = '0;
        end else if (accept) begin
            case (state_q)
                HEADER: begin
                    len_d = len_shift;
                    if (byte_cnt_q == 8'(LEN_BYTES - 1)) begin
                        byte_cnt_d     = '0;
                        word_cnt_d     = '0;
                        loaded_words_d = ADDR_WIDTH'(len_shift);
                        if (len_shift == '0) begin
                            if (CHECKSUM_EN != 0) begin
                                state_d = CHECK;
                            end else begin
                                state_d   = EXEC;
                                in_exec_d = 1'b1;
                            end
                        end else begin
                            state_d = PAYLOAD;
                        end
                    end else begin
                        byte_cnt_d = byte_cnt_q + 8'd1;
                    end
                end

                PAYLOAD: begin
                    word_d = word_next;
                    csum_d = csum_q + rx_data;
                    if (byte_cnt_q == 8'(WORD_BYTES - 1)) begin
                        byte_cnt_d = '0;
                        we_d       = 1'b1;
                        wdata_d    = word_next;
                        waddr_d    = addr_q;
                        addr_d     = addr_q + ADDR_WIDTH'(1);
                        word_cnt_d = word_cnt_q + LEN_W'(1);
                        if (last_word) begin
                            if (CHECKSUM_EN != 0) begin
                                state_d = CHECK;
                            end else begin
                                state_d   = EXEC;
                                in_exec_d = 1'b1;
                            end
                        end
                    end else begin
                        byte_cnt_d = byte_cnt_q + 8'd1;
                    end
                end

                CHECK: begin
                    if (rx_data == csum_q) begin
                        load_err_d = 1'b0;
                        state_d    = EXEC;
                        in_exec_d  = 1'b1;
                    end else begin
                        load_err_d = 1'b1;
                        state_d    = HEADER;
                        len_d      = '0;
                        word_cnt_d = '0;
                        byte_cnt_d = '0;
                        word_d     = '0;
                        csum_d     = '0;
                        addr_d     = '0;
                    end
                end

                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    // All loader state lives in this one register bank, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= HEADER;
            len_q          <= '0;
            word_cnt_q     <= '0;
            byte_cnt_q     <= '0;
            word_q         <= '0;
            csum_q         <= '0;
            addr_q         <= '0;
            we_q           <= 1'b0;
            waddr_q        <= '0;
            wdata_q        <= '0;
            in_exec_q      <= 1'b0;
            load_err_q     <= 1'b0;
            loaded_words_q <= '0;
        end else begin
            state_q        <= state_d;
            len_q          <= len_d;
            word_cnt_q     <= word_cnt_d;
            byte_cnt_q     <= byte_cnt_d;
            word_q         <= word_d;
            csum_q         <= csum_d;
            addr_q         <= addr_d;
            we_q           <= we_d;
            waddr_q        <= waddr_d;
            wdata_q        <= wdata_d;
            in_exec_q      <= in_exec_d;
            load_err_q     <= load_err_d;
            loaded_words_q <= loaded_words_d;
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader. Two loaders (big- and little-endian
// word packing) share one byte stream; every expected memory write is queued
// when its last byte is driven and compared when the write strobe appears.
module tb_program_loader;

    typedef struct packed {
        logic [15:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        restart;

    logic        pop_be, we_be, exec_be, err_be;
    logic [15:0] addr_be, words_be;
    logic [31:0] data_be;
    logic        pop_le, we_le, exec_le, err_le;
    logic [15:0] addr_le, words_le;
    logic [31:0] data_le;

    wr_t         exp_be[$];
    wr_t         exp_le[$];
    wr_t         eBe, eLe;
    logic [31:0] streamWords [4];
    int          expAddr;
    int          checkCount = 0;
    int          errorCount = 0;
    logic        prevWeBe = 1'b0;
    logic        prevWeLe = 1'b0;

    program_loader dut_be (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_pop(pop_be), .restart(restart), .write_enable(we_be),
        .write_address(addr_be), .write_data(data_be), .in_execution(exec_be),
        .load_error(err_be), .loaded_words(words_be)
    );

    program_loader #(.BIG_ENDIAN(0)) dut_le (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_pop(pop_le), .restart(restart), .write_enable(we_le),
        .write_address(addr_le), .write_data(data_le), .in_execution(exec_le),
        .load_error(err_le), .loaded_words(words_le)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change one time unit after the falling edge.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Offer one byte (optionally after an idle cycle) until it is popped.
    task automatic applyStimulus(input logic [7:0] b, input bit gap);
        bit done;
        done = 1'b0;
        if (gap) begin
            rx_valid = 1'b0;
            tick();
        end
        rx_data  = b;
        rx_valid = 1'b1;
        for (int n = 0; n < 50 && !done; n++) begin
            #1;
            done = (pop_be === 1'b1);
            tick();
        end
        rx_valid = 1'b0;
        if (!done) checkOutput("pop_timeout", 64'd0, 64'd1);
    endtask

    // Send header, streamWords[0..n-1] MSB-first and a checksum byte.
    task automatic sendStream(input int n, input bit badSum, input bit gap);
        logic [7:0]  sum;
        logic [7:0]  b;
        logic [31:0] w;
        sum     = 8'd0;
        expAddr = 0;
        applyStimulus(8'(n >> 8), gap);
        applyStimulus(8'(n), gap);
        for (int i = 0; i < n; i++) begin
            w = streamWords[i];
            for (int k = 0; k < 4; k++) begin
                b = w[31 - 8*k -: 8];
                if (k == 3) begin
                    exp_be.push_back({16'(expAddr), w});
                    exp_le.push_back({16'(expAddr), w[7:0], w[15:8], w[23:16], w[31:24]});
                    expAddr++;
                end
                sum = sum + b;
                applyStimulus(b, gap);
            end
        end
        checkOutput("exec_before_sum", exec_be, 64'd0);
        applyStimulus(badSum ? sum + 8'd1 : sum, gap);
    endtask

    // Write monitor: compares each strobe with the queued expectation and
    // watches that nothing is popped while the FIFO is empty.
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            if (rx_valid === 1'b0) begin
                checkOutput("pop_be_novalid", pop_be, 64'd0);
                checkOutput("pop_le_novalid", pop_le, 64'd0);
            end
            if (we_be === 1'b1) begin
                checkOutput("we_be_single", prevWeBe, 64'd0);
                if (exp_be.size() == 0) begin
                    checkOutput("we_be_unexpected", 64'd1, 64'd0);
                end else begin
                    eBe = exp_be.pop_front();
                    checkOutput("waddr_be", addr_be, eBe.addr);
                    checkOutput("wdata_be", data_be, eBe.data);
                end
            end
            if (we_le === 1'b1) begin
                checkOutput("we_le_single", prevWeLe, 64'd0);
                if (exp_le.size() == 0) begin
                    checkOutput("we_le_unexpected", 64'd1, 64'd0);
                end else begin
                    eLe = exp_le.pop_front();
                    checkOutput("waddr_le", addr_le, eLe.addr);
                    checkOutput("wdata_le", data_le, eLe.data);
                end
            end
        end
        prevWeBe = we_be;
        prevWeLe = we_le;
    end

    // Main sequence.
    initial begin
        reset    = 1'b1;
        restart  = 1'b0;
        rx_valid = 1'b1;
        rx_data  = 8'h00;
        tick();
        tick();
        checkOutput("rst_pop", pop_be, 64'd0);
        checkOutput("rst_exec", exec_be, 64'd0);
        checkOutput("rst_we", we_be, 64'd0);
        checkOutput("rst_waddr", addr_be, 64'd0);
        checkOutput("rst_wdata", data_be, 64'd0);
        checkOutput("rst_err", err_be, 64'd0);
        checkOutput("rst_words", words_be, 64'd0);
        rx_valid = 1'b0;
        reset    = 1'b0;
        tick();

        // Basic two-word load, back-to-back bytes.
        $display("[TB] basic load");
        streamWords[0] = 32'h11223344;
        streamWords[1] = 32'h55667788;
        sendStream(2, 1'b0, 1'b0);
        checkOutput("t1_exec_be", exec_be, 64'd1);
        checkOutput("t1_exec_le", exec_le, 64'd1);
        checkOutput("t1_err", err_be, 64'd0);
        checkOutput("t1_words", words_be, 64'd2);
        tick();
        checkOutput("t1_exec_hold", exec_be, 64'd1);

        // Restart from EXEC with a byte waiting: not popped, exec drops.
        $display("[TB] restart from exec");
        restart  = 1'b1;
        rx_valid = 1'b1;
        rx_data  = 8'hAA;
        #1;
        checkOutput("t2_pop_be", pop_be, 64'd0);
        checkOutput("t2_pop_le", pop_le, 64'd0);
        checkOutput("t2_exec_pre", exec_be, 64'd1);
        tick();
        restart  = 1'b0;
        rx_valid = 1'b0;
        checkOutput("t2_exec_be", exec_be, 64'd0);
        checkOutput("t2_exec_le", exec_le, 64'd0);
        checkOutput("t2_words_held", words_be, 64'd2);

        // Bad checksum: writes happen, error flagged, no execution.
        $display("[TB] bad checksum");
        sendStream(2, 1'b1, 1'b0);
        checkOutput("t3_err", err_be, 64'd1);
        checkOutput("t3_exec", exec_be, 64'd0);
        tick();
        tick();
        checkOutput("t3_exec_hold", exec_be, 64'd0);

        // Good stream with rx_valid toggling; loads from 0 and clears the error.
        $display("[TB] gapped reload");
        streamWords[0] = 32'hDEADBEEF;
        streamWords[1] = 32'h0BADF00D;
        streamWords[2] = 32'h12345678;
        sendStream(3, 1'b0, 1'b1);
        checkOutput("t4_err", err_be, 64'd0);
        checkOutput("t4_exec", exec_be, 64'd1);
        checkOutput("t4_words", words_be, 64'd3);

        // Empty program: no writes, checksum 0x00 accepted.
        $display("[TB] empty program");
        restart = 1'b1;
        tick();
        restart = 1'b0;
        sendStream(0, 1'b0, 1'b0);
        checkOutput("t5_exec", exec_be, 64'd1);
        checkOutput("t5_words", words_be, 64'd0);
        checkOutput("t5_err", err_be, 64'd0);

        // Asynchronous reset mid-payload, then a full reload.
        $display("[TB] async reset");
        restart = 1'b1;
        tick();
        restart = 1'b0;
        applyStimulus(8'h00, 1'b0);
        applyStimulus(8'h02, 1'b0);
        applyStimulus(8'h11, 1'b0);
        applyStimulus(8'h22, 1'b0);
        applyStimulus(8'h33, 1'b0);
        checkOutput("t6_words_pre", words_be, 64'd2);
        rx_valid = 1'b1;
        rx_data  = 8'h44;
        #2;
        reset = 1'b1;
        #1;
        checkOutput("t6_pop", pop_be, 64'd0);
        checkOutput("t6_words", words_be, 64'd0);
        checkOutput("t6_wdata", data_be, 64'd0);
        checkOutput("t6_waddr", addr_be, 64'd0);
        checkOutput("t6_exec", exec_be, 64'd0);
        checkOutput("t6_we", we_be, 64'd0);
        tick();
        rx_valid = 1'b0;
        reset    = 1'b0;
        tick();
        streamWords[0] = 32'h11223344;
        streamWords[1] = 32'h55667788;
        sendStream(2, 1'b0, 1'b0);
        checkOutput("t6_exec_after", exec_be, 64'd1);
        checkOutput("t6_err_after", err_be, 64'd0);

        tick();
        tick();
        checkOutput("queue_be_empty", 64'(exp_be.size()), 64'd0);
        checkOutput("queue_le_empty", 64'(exp_le.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
